// File: rtl/fpga_tcam_sweep.sv
// rtl/fpga_tcam_sweep.sv - segmented-RAM ternary CAM with sweep-update FSM and RPNUM search ports
// Optional build macro: FPGA_TCAM_MHIT_EN adds the per-port mMulti multi-hit output.
module fpga_tcam_sweep #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 36,
    parameter int SEGW  = 9,
    parameter int RPNUM = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wReq,
    output logic                   wRdy,
    input  logic                   wOp,
    input  logic [AW-1:0]          wAddr,
    input  logic [WIDTH-1:0]       wPatt,
    input  logic [WIDTH-1:0]       wMask,
    input  logic [RPNUM-1:0]       mReq,
    input  logic [RPNUM*WIDTH-1:0] mPatt,
    output logic [RPNUM-1:0]       mVld,
    output logic [RPNUM-1:0]       match,
`ifdef FPGA_TCAM_MHIT_EN
    output logic [RPNUM-1:0]       mMulti,
`endif
    output logic [RPNUM*AW-1:0]    mAddr
);
    localparam int L    = WIDTH / SEGW;
    localparam int ROWS = 1 << SEGW;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t             state, state_nx;
    logic [SEGW:0]      row;
    logic [AW-1:0]      addr_q;
    logic [WIDTH-1:0]   patt_q, mask_q;
    logic [DEPTH-1:0]   valid;
    logic               accept_wr, accept_er, tbl_we;
    logic [L-1:0]       seg_bit;
    logic [RPNUM-1:0]   req_q;

    always_comb begin
        state_nx  = state;
        wRdy      = 1'b0;
        accept_wr = 1'b0;
        accept_er = 1'b0;
        tbl_we    = 1'b0;
        case (state)
            IDLE: begin
                wRdy = 1'b1;
                if (wReq) begin
                    if (wOp) begin
                        accept_er = 1'b1;
                    end else begin
                        accept_wr = 1'b1;
                        state_nx  = SWEEP;
                    end
                end
            end
            SWEEP: begin
                tbl_we = 1'b1;
                if (row == (SEGW+1)'(ROWS-1)) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            row    <= '0;
            addr_q <= '0;
            patt_q <= '0;
            mask_q <= '0;
            valid  <= '0;
        end else begin
            state <= state_nx;
            if (accept_wr) begin
                row    <= '0;
                addr_q <= wAddr;
                patt_q <= wPatt;
                mask_q <= wMask;
            end else if (tbl_we) begin
                row <= row + (SEGW+1)'(1);
            end
            // Entry is hidden from searches from the accept edge until the sweep completes
            if (accept_wr || accept_er) valid[wAddr] <= 1'b0;
            else if (state == DONE) valid[addr_q] <= 1'b1;
        end
    end

    always_comb begin
        seg_bit = '0;
        for (int s = 0; s < L; s++) begin
            seg_bit[s] = ((row[SEGW-1:0] & ~mask_q[s*SEGW +: SEGW]) ==
                          (patt_q[s*SEGW +: SEGW] & ~mask_q[s*SEGW +: SEGW]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_q <= '0;
        else     req_q <= mReq;
    end

    logic [RPNUM*DEPTH-1:0] hits_all;

    for (genvar p = 0; p < RPNUM; p++) begin : g_port
        // Private table copy per port; every copy receives the same sweep writes
        logic [DEPTH-1:0] ram [L][ROWS];
        logic [DEPTH-1:0] rd_q [L];
        logic [DEPTH-1:0] and_rows;

        always_ff @(posedge clk) begin
            for (int s = 0; s < L; s++) begin
                if (tbl_we) ram[s][row[SEGW-1:0]][addr_q] <= seg_bit[s];
                rd_q[s] <= ram[s][mPatt[p*WIDTH + s*SEGW +: SEGW]];
            end
        end

        always_comb begin
            and_rows = valid;
            for (int s = 0; s < L; s++) and_rows = and_rows & rd_q[s];
        end

        assign hits_all[p*DEPTH +: DEPTH] = and_rows;
    end

    logic [DEPTH-1:0]    hv;
    logic [RPNUM-1:0]    hit_any;
    logic [RPNUM*AW-1:0] enc;
`ifdef FPGA_TCAM_MHIT_EN
    logic [RPNUM-1:0]    hit_multi;
`endif

    always_comb begin
        hv      = '0;
        hit_any = '0;
        enc     = '0;
`ifdef FPGA_TCAM_MHIT_EN
        hit_multi = '0;
`endif
        for (int p = 0; p < RPNUM; p++) begin
            hv         = hits_all[p*DEPTH +: DEPTH];
            hit_any[p] = |hv;
`ifdef FPGA_TCAM_MHIT_EN
            hit_multi[p] = |(hv & (hv - DEPTH'(1)));
`endif
            // Descending scan so the lowest set index is the one left in enc
            for (int i = DEPTH-1; i >= 0; i--) begin
                if (hv[i]) enc[p*AW +: AW] = AW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mVld  <= '0;
            match <= '0;
            mAddr <= '0;
        end else begin
            mVld  <= req_q;
            match <= req_q & hit_any;
            for (int p = 0; p < RPNUM; p++) begin
                mAddr[p*AW +: AW] <= (req_q[p] && hit_any[p]) ? enc[p*AW +: AW] : '0;
            end
        end
    end

`ifdef FPGA_TCAM_MHIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mMulti <= '0;
        else     mMulti <= req_q & hit_multi;
    end
`endif

endmodule

// File: tb/tb_fpga_tcam_sweep.sv
// tb/tb_fpga_tcam_sweep.sv - scoreboard bench for fpga_tcam_sweep (honours FPGA_TCAM_MHIT_EN)
module tb_fpga_tcam_sweep;
    localparam int DEPTH = 64;
    localparam int WIDTH = 36;
    localparam int SEGW  = 9;
    localparam int RPNUM = 2;
    localparam int AW    = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   wReq = 1'b0;
    logic                   wRdy;
    logic                   wOp = 1'b0;
    logic [AW-1:0]          wAddr = '0;
    logic [WIDTH-1:0]       wPatt = '0;
    logic [WIDTH-1:0]       wMask = '0;
    logic [RPNUM-1:0]       mReq = '0;
    logic [RPNUM*WIDTH-1:0] mPatt = '0;
    logic [RPNUM-1:0]       mVld;
    logic [RPNUM-1:0]       match;
    logic [RPNUM*AW-1:0]    mAddr;
`ifdef FPGA_TCAM_MHIT_EN
    logic [RPNUM-1:0]       mMulti;
`endif

    fpga_tcam_sweep #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEGW(SEGW), .RPNUM(RPNUM)) dut (
        .clk(clk), .rst(rst),
        .wReq(wReq), .wRdy(wRdy), .wOp(wOp), .wAddr(wAddr), .wPatt(wPatt), .wMask(wMask),
        .mReq(mReq), .mPatt(mPatt), .mVld(mVld), .match(match),
`ifdef FPGA_TCAM_MHIT_EN
        .mMulti(mMulti),
`endif
        .mAddr(mAddr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          m;
        logic [AW-1:0] a;
        logic          mu;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        bit   have;
        logic ok;
        if (rst) return;
        for (int p = 0; p < RPNUM; p++) begin
            have = 1'b0;
            if (p == 0 && q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); have = 1'b1; end
            if (p == 1 && q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
            if (have) begin
                vectors++;
                ok = mVld[p] && (e.cyc == cyc) && (match[p] === e.m) && (mAddr[p*AW +: AW] === e.a);
`ifdef FPGA_TCAM_MHIT_EN
                ok = ok && (mMulti[p] === e.mu);
`endif
                if (!ok) begin
                    miscompares++;
                    $display("FAIL search port%0d cyc%0d: vld=%b match=%b addr=%h expected vld=1 match=%b addr=%h mu=%b due cyc%0d",
                             p, cyc, mVld[p], match[p], mAddr[p*AW +: AW], e.m, e.a, e.mu, e.cyc);
                end
            end else if (mVld[p] !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_vld port%0d cyc%0d: got %b expected 0", p, cyc, mVld[p]);
            end
        end
    endtask

    always @(negedge clk) mon();

    task automatic issue(input int p, input logic [WIDTH-1:0] key,
                         input logic m, input logic [AW-1:0] a, input logic mu);
        exp_t e;
        mReq[p] = 1'b1;
        mPatt[p*WIDTH +: WIDTH] = key;
        e.cyc = cyc + 2;
        e.m   = m;
        e.a   = a;
        e.mu  = mu;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        mReq = '0;
    endtask

    task automatic drain();
        repeat (3) step();
    endtask

    task automatic wr(input logic op, input logic [AW-1:0] a, input logic [WIDTH-1:0] p,
                      input logic [WIDTH-1:0] m, input bit wait_done);
        int lows  = 0;
        int guard = 0;
        while (wRdy !== 1'b1 && guard < 2000) begin step(); guard++; end
        wReq = 1'b1; wOp = op; wAddr = a; wPatt = p; wMask = m;
        step();
        wReq = 1'b0;
        if (op) begin
            check("erase_keeps_rdy", wRdy, 1);
        end else if (wait_done) begin
            while (wRdy !== 1'b1 && lows < 2000) begin lows++; step(); end
            check("sweep_busy_len", lows, 513);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wrdy", wRdy, 1);
        check("rst_mvld", mVld, 0);
        check("rst_match", match, 0);
        check("rst_maddr", mAddr, 0);
        rst = 1'b0;
        step();

        // empty table misses
        issue(0, 36'h1234, 0, 6'h00, 0); step(); drain();

        // single exact entry
        wr(0, 6'h10, 36'h1234, 36'h0, 1);
        issue(0, 36'h1234, 1, 6'h10, 0); issue(1, 36'h1235, 0, 6'h00, 0); step();
        issue(1, 36'h1234, 1, 6'h10, 0); issue(0, 36'h1235, 0, 6'h00, 0); step();
        drain();

        // ternary entry, then a second overlapping entry at a higher address
        wr(0, 6'h05, 36'h00000ff00, 36'h0000000ff, 1);
        issue(0, 36'h00000ff3c, 1, 6'h05, 0); issue(1, 36'h1234, 1, 6'h10, 0); step(); drain();
        wr(0, 6'h10, 36'h00000ff00, 36'h0000000ff, 1);
        issue(0, 36'h00000ff3c, 1, 6'h05, 1); issue(1, 36'h00000ff00, 1, 6'h05, 1); step();
        issue(0, 36'h1234, 0, 6'h00, 0); issue(1, 36'h00000fe3c, 0, 6'h00, 0); step();
        drain();

        // erases
        wr(1, 6'h05, 36'h0, 36'h0, 0);
        issue(0, 36'h00000ff3c, 1, 6'h10, 0); step(); drain();
        wr(1, 6'h10, 36'h0, 36'h0, 0);
        issue(0, 36'h00000ff3c, 0, 6'h00, 0); issue(1, 36'h00000ff00, 0, 6'h00, 0); step(); drain();

        // overwrite removes the old pattern
        wr(0, 6'h10, 36'h1234, 36'h0, 1);
        wr(0, 6'h10, 36'h5678, 36'h0, 1);
        issue(0, 36'h1234, 0, 6'h00, 0); issue(1, 36'h5678, 1, 6'h10, 0); step(); drain();

        // search during sweep, ignored request, reset mid-sweep
        wr(0, 6'h05, 36'h00000ff00, 36'h0000000ff, 1);
        wr(0, 6'h10, 36'h5678, 36'h0, 0);
        for (int i = 0; i < 200; i++) begin
            issue(1, 36'h5678, 0, 6'h00, 0);
            issue(0, 36'h00000ff3c, 1, 6'h05, 0);
            if (i == 50) begin wReq = 1'b1; wOp = 1'b1; wAddr = 6'h05; end
            if (i == 51) wReq = 1'b0;
            if (i == 100) check("sweep_wrdy_low", wRdy, 0);
            step();
        end
        rst = 1'b1;
        #1;
        check("midsweep_rst_wrdy", wRdy, 1);
        check("midsweep_rst_mvld", mVld, 0);
        repeat (2) @(negedge clk);
        q0.delete();
        q1.delete();
        rst = 1'b0;
        issue(1, 36'h5678, 0, 6'h00, 0); issue(0, 36'h00000ff3c, 0, 6'h00, 0); step();
        issue(0, 36'h1234, 0, 6'h00, 0); issue(1, 36'h00000ff00, 0, 6'h00, 0); step();
        drain();
        check("scoreboard_empty", q0.size() + q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
